// File: rtl/counter_seq_monitor_pkg.sv
// Shared types and defaults for the counter sequence monitor.
// State encoding is fixed; the unused code 2'b11 behaves as IDLE.
package counter_mon_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 2;
  localparam int unsigned DEFAULT_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ERROR = 2'b10
  } mon_state_t;

endpackage

// File: rtl/counter_seq_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
module sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_seq_monitor.sv
// Locks onto a free-running counter, checks +1 progression each enabled
// sample, counts wraps and latches diagnostics on the first break.
module counter_seq_monitor
  import counter_mon_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     counter_in,
  input  logic                 en_in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 wrap_pulse,
  output logic [CNT_WIDTH-1:0] wrap_count,
  output logic                 seq_error,
  output logic [WIDTH-1:0]     err_expected,
  output logic [WIDTH-1:0]     err_got
);

  mon_state_t       state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_val;
  logic             seq_ok;
  logic             wrap_hit;

  assign exp_val  = prev + 1'b1;
  assign seq_ok   = (counter_in == exp_val);
  // Wrap is a good sample whose predecessor was the maximum value.
  assign wrap_hit = en_in && (state == TRACK) && seq_ok && (prev == '1);

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (wrap_hit),
    .count (wrap_count)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state        <= IDLE;
      prev         <= '0;
      err_expected <= '0;
      err_got      <= '0;
      locked       <= 1'b0;
      seq_error    <= 1'b0;
      wrap_pulse   <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      case (state)
        TRACK: begin
          if (en_in) begin
            if (seq_ok) begin
              prev       <= counter_in;
              wrap_pulse <= wrap_hit;
            end else begin
              err_expected <= exp_val;
              err_got      <= counter_in;
              state        <= ERROR;
              locked       <= 1'b0;
              seq_error    <= 1'b1;
            end
          end
        end
        ERROR: begin
        end
        default: begin
          if (en_in) begin
            prev   <= counter_in;
            state  <= TRACK;
            locked <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_monitor.sv
// Directed self-checking bench for counter_seq_monitor (WIDTH=2, CNT_WIDTH=4).
module tb_counter_seq_monitor;

  logic       clk;
  logic       reset;
  logic [1:0] counter_in;
  logic       en_in;
  logic       clear;
  logic       locked;
  logic       wrap_pulse;
  logic [3:0] wrap_count;
  logic       seq_error;
  logic [1:0] err_expected;
  logic [1:0] err_got;
  logic [10:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  counter_seq_monitor #(
    .WIDTH     (2),
    .CNT_WIDTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .counter_in   (counter_in),
    .en_in        (en_in),
    .clear        (clear),
    .locked       (locked),
    .wrap_pulse   (wrap_pulse),
    .wrap_count   (wrap_count),
    .seq_error    (seq_error),
    .err_expected (err_expected),
    .err_got      (err_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {locked, wrap_pulse, wrap_count, seq_error, err_expected, err_got};

  function automatic logic [10:0] mk(input logic l, input logic wp, input logic [3:0] wc,
                                     input logic se, input logic [1:0] ee, input logic [1:0] eg);
    return {l, wp, wc, se, ee, eg};
  endfunction

  // Apply inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic [1:0] v, input logic e, input logic r, input logic c);
    counter_in = v;
    en_in      = e;
    reset      = r;
    clear      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'(i), 1'b1, 1'b1, 1'b0);
      n_assert++;
      if (obs !== 11'd0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, obs, 11'd0);
      end
    end
  endtask

  task automatic test_sequence();
    logic [1:0]  v  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [10:0] ex [6];
    ex[0] = mk(1, 0, 0, 0, 0, 0);
    ex[1] = mk(1, 0, 0, 0, 0, 0);
    ex[2] = mk(1, 0, 0, 0, 0, 0);
    ex[3] = mk(1, 0, 0, 0, 0, 0);
    ex[4] = mk(1, 1, 1, 0, 0, 0);
    ex[5] = mk(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(v[i], 1'b1, 1'b0, 1'b0);
      n_assert++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL sequence step %0d: got %h expected %h", i, obs, ex[i]);
      end
    end
    step(2'd2, 1'b1, 1'b1, 1'b0);
    n_assert++;
    if (obs !== 11'd0) begin
      n_fail++;
      $display("FAIL sequence_reset: got %h expected %h", obs, 11'd0);
    end
  endtask

  task automatic test_error();
    logic [1:0]  v  [8] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [10:0] ex [8];
    ex[0] = mk(1, 0, 0, 0, 0, 0);
    ex[1] = mk(1, 0, 0, 0, 0, 0);
    for (int i = 2; i < 8; i++) ex[i] = mk(0, 0, 0, 1, 2'd2, 2'd3);
    for (int i = 0; i < 8; i++) begin
      step(v[i], 1'b1, 1'b0, 1'b0);
      n_assert++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL error step %0d: got %h expected %h", i, obs, ex[i]);
      end
    end
    step(2'd1, 1'b1, 1'b0, 1'b1);
    n_assert++;
    if (obs !== 11'd0) begin
      n_fail++;
      $display("FAIL error_clear: got %h expected %h", obs, 11'd0);
    end
  endtask

  task automatic test_gap();
    logic [10:0] ex;
    step(2'd2, 1'b1, 1'b0, 1'b0);
    ex = mk(1, 0, 0, 0, 0, 0);
    n_assert++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL gap_lock: got %h expected %h", obs, ex);
    end
    for (int i = 0; i < 5; i++) begin
      step(2'd0, 1'b0, 1'b0, 1'b0);
      n_assert++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL gap_idle %0d: got %h expected %h", i, obs, ex);
      end
    end
    step(2'd3, 1'b1, 1'b0, 1'b0);
    n_assert++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL gap_resume: got %h expected %h", obs, ex);
    end
    step(2'd0, 1'b1, 1'b0, 1'b0);
    ex = mk(1, 1, 1, 0, 0, 0);
    n_assert++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL gap_wrap: got %h expected %h", obs, ex);
    end
    step(2'd1, 1'b1, 1'b0, 1'b0);
    ex = mk(1, 0, 1, 0, 0, 0);
    n_assert++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL gap_after_wrap: got %h expected %h", obs, ex);
    end
  endtask

  task automatic test_saturation();
    logic [10:0] ex;
    logic [3:0]  wc;
    step(2'd0, 1'b0, 1'b1, 1'b0);
    step(2'd0, 1'b1, 1'b0, 1'b0);
    for (int w = 1; w <= 18; w++) begin
      wc = (w >= 15) ? 4'd15 : 4'(w);
      step(2'd1, 1'b1, 1'b0, 1'b0);
      step(2'd2, 1'b1, 1'b0, 1'b0);
      step(2'd3, 1'b1, 1'b0, 1'b0);
      ex = mk(1, 0, (w == 1) ? 4'd0 : ((w - 1 >= 15) ? 4'd15 : 4'(w - 1)), 0, 0, 0);
      n_assert++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL sat_pre_wrap %0d: got %h expected %h", w, obs, ex);
      end
      step(2'd0, 1'b1, 1'b0, 1'b0);
      ex = mk(1, 1, wc, 0, 0, 0);
      n_assert++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL sat_wrap %0d: got %h expected %h", w, obs, ex);
      end
    end
  endtask

  task automatic test_reset_clear();
    logic [10:0] ex;
    step(2'd0, 1'b0, 1'b1, 1'b0);
    step(2'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(2'd1, 1'b1, 1'b0, 1'b0);
      step(2'd2, 1'b1, 1'b0, 1'b0);
      step(2'd3, 1'b1, 1'b0, 1'b0);
      step(2'd0, 1'b1, 1'b0, 1'b0);
    end
    step(2'd1, 1'b1, 1'b0, 1'b0);
    ex = mk(1, 0, 4'd2, 0, 0, 0);
    n_assert++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL rc_before: got %h expected %h", obs, ex);
    end
    step(2'd2, 1'b1, 1'b1, 1'b1);
    n_assert++;
    if (obs !== 11'd0) begin
      n_fail++;
      $display("FAIL rc_both: got %h expected %h", obs, 11'd0);
    end
    step(2'd3, 1'b1, 1'b0, 1'b0);
    ex = mk(1, 0, 0, 0, 0, 0);
    n_assert++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL rc_relock: got %h expected %h", obs, ex);
    end
    step(2'd0, 1'b1, 1'b0, 1'b0);
    ex = mk(1, 1, 4'd1, 0, 0, 0);
    n_assert++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL rc_wrap: got %h expected %h", obs, ex);
    end
  endtask

  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    en_in      = 1'b1;
    counter_in = 2'd0;
    test_reset();
    test_sequence();
    test_error();
    test_gap();
    test_saturation();
    test_reset_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
